cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 16-bit FSM CPU. It sequences fetch, decode, execute, memory, I/O and writeback phases, and generates all datapath strobes (fetch_en, exec_en, wb_en, data-memory request, input-buffer pop, output-buffer push). It adds req/ack handshakes for data memory and I/O, run/step/halt debug control, a memory timeout fault and a retired-instruction counter. It sits between program memory/decode fields and the register file, ALU, data memory and I/O buffers.

Parameters:
MEM_TIMEOUT, 15, maximum cycles mem_req may stay high without mem_ack before FAULT (range 1..255)
ICNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
opcode  in  3  inst[15:13] of the current instruction, stable from DECODE onward
mode  in  1  inst[12]
run  in  1  level; continuous execution while high
step  in  1  single-cycle pulse; execute exactly one instruction from HALT
halt_req  in  1  level; stop at the next instruction boundary
mem_ack  in  1  data memory completed the access
in_valid  in  1  input buffer holds a word
out_ready  in  1  output buffer can accept a word
fetch_en  out  1  PC increment and instruction latch
exec_en  out  1  ALU execute strobe
wb_en  out  1  register file write enable
mem_req  out  1  data memory request, held until ack
mem_we  out  1  store qualifier; valid only while mem_req=1
in_pop  out  1  consume input word
out_push  out  1  write output word
state  out  4  current seq_state_t, for debug
halted  out  1  high in HALT
fault  out  1  sticky memory-timeout flag
instr_count  out  ICNT_W  retired instructions, wraps

Behaviour:
- Opcode map (mode in parentheses): 000-011 ALU op, result written back; 100 LOAD; 101 STORE; 110 IN(0)/OUT(1); 111 HALT(0)/NOP(1).
- States: HALT, FETCH, DECODE, EXEC, MEM, IO, WB, FAULT. Moore outputs decoded from the state register plus in_valid/out_ready/mem_ack where noted.
- Reset: state=HALT, step_mode=0, timeout count=0, fault=0, instr_count=0. All strobes 0, halted=1. rst mid-instruction aborts at the next edge with no further strobes.
- HALT: run=1 -> FETCH, step_mode=0. step=1 (with run=0) -> FETCH, step_mode=1. halt_req=1 blocks leaving HALT.
- FETCH: fetch_en=1 for 1 cycle -> DECODE.
- DECODE: 1 cycle, no strobes.
  - ALU -> EXEC.
  - LOAD/STORE -> MEM; the timeout count clears on entry.
  - IN/OUT -> IO.
  - HALT op -> HALT and retires.
  - NOP retires -> boundary.
- EXEC: exec_en=1 for 1 cycle -> WB.
- MEM: mem_req=1 every cycle; mem_we=1 for STORE.
  - mem_ack in any MEM cycle, including the first, completes the access. LOAD -> WB; STORE retires -> boundary.
  - If no ack is seen within MEM_TIMEOUT cycles of MEM entry -> FAULT. An ack on cycle MEM_TIMEOUT is accepted.
  - mem_ack outside MEM is ignored.
- IO: no timeout.
  - IN: in_pop = in_valid; when in_valid=1 -> WB.
  - OUT: out_push = out_ready; when out_ready=1, retire -> boundary.
- WB: wb_en=1 for 1 cycle; retire -> boundary.
- Boundary rule: if halt_req, step_mode, or run=0, go to HALT (clear step_mode); else go to FETCH. halt_req has priority over run. step while not in HALT is ignored.
- Retire: instr_count increments by 1 (mod 2^ICNT_W) on the cycle the instruction leaves its last state. HALT op and NOP count.
- FAULT: all strobes 0, fault=1, halted=0. Only rst exits FAULT.
- Latencies from FETCH, zero-wait: ALU 4 cycles, LOAD 4, STORE 3, IN 4, OUT 3, NOP 2.

Decomposition:
- cpu_pkg holds:
  - seq_state_t: 4-bit enum, distinct from the existing state_t.
  - Opcode localparams: OP_LOAD=3'b100, OP_STORE=3'b101, OP_IO=3'b110, OP_SYS=3'b111.
  - is_alu(opcode) helper function.
- One sub-module, seq_timeout: loadable down-counter with clear, enable and expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- rst, run=1, opcode=000 repeatedly -> fetch_en/exec_en/wb_en pulse every 4 cycles; instr_count=3 after 12 cycles.
- LOAD with mem_ack delayed 3 cycles -> mem_req high exactly 4 cycles, mem_we=0, then wb_en 1 cycle. STORE with ack in the first MEM cycle -> mem_req and mem_we high 1 cycle, no wb_en.
- MEM_TIMEOUT=4, LOAD, ack never -> mem_req high 4 cycles, then state=FAULT, fault=1. run toggling has no effect; rst clears fault.
- IN with in_valid low 5 cycles then high -> in_pop single cycle coincident with in_valid, then wb_en. OUT with out_ready=1 -> out_push 1 cycle, no wb_en.
- From HALT, step pulse with opcode=000 -> one instruction, return to HALT, instr_count +1. halt_req during EXEC of a running program -> HALT right after WB.
- Opcode 111 mode 0 -> HALT after DECODE, halted=1, instr_count +1. Mode 1 -> continues to FETCH 2 cycles after the previous FETCH. rst asserted in MEM -> HALT next edge, mem_req=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and opcode constants for the multi-cycle CPU control path.
package cpu_pkg;

  typedef enum logic [3:0] {
    SEQ_HALT   = 4'd0,
    SEQ_FETCH  = 4'd1,
    SEQ_DECODE = 4'd2,
    SEQ_EXEC   = 4'd3,
    SEQ_MEM    = 4'd4,
    SEQ_IO     = 4'd5,
    SEQ_WB     = 4'd6,
    SEQ_FAULT  = 4'd7
  } seq_state_t;

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_IO    = 3'b110;
  localparam logic [2:0] OP_SYS   = 3'b111;

  // Opcodes 000-011 are ALU operations with a register writeback.
  function automatic logic is_alu(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/seq_timeout.sv
// Down-counter bounding how long a data-memory request may wait for its ack.
module seq_timeout #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  logic en,
  output logic expired
);

  // Loaded with MEM_TIMEOUT-1 so it reads zero on the last allowed MEM cycle.
  localparam logic [7:0] LOAD_VAL = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == 8'd0);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/IO/writeback sequencing,
// debug run/step/halt control, memory-timeout fault and retired-instruction count.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ICNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        opcode,
  input  logic              mode,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  input  logic              mem_ack,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              fetch_en,
  output logic              exec_en,
  output logic              wb_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic              in_pop,
  output logic              out_push,
  output logic [3:0]        state,
  output logic              halted,
  output logic              fault,
  output logic [ICNT_W-1:0] instr_count
);

  seq_state_t        state_q;
  seq_state_t        boundary_state;
  logic              step_mode;
  logic              fault_q;
  logic [ICNT_W-1:0] icount;
  logic              is_load, is_store, is_in, is_out, is_haltop;
  logic              tmo_load, tmo_en, tmo_expired;

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_in     = (opcode == OP_IO)  && !mode;
  assign is_out    = (opcode == OP_IO)  &&  mode;
  assign is_haltop = (opcode == OP_SYS) && !mode;

  // halt_req wins over run; a stepped instruction always returns to HALT.
  assign boundary_state = (halt_req || step_mode || !run) ? SEQ_HALT : SEQ_FETCH;

  assign tmo_load = (state_q == SEQ_DECODE) && (is_load || is_store);
  assign tmo_en   = (state_q == SEQ_MEM);

  seq_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk     (clk),
    .clear   (rst),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SEQ_HALT;
      step_mode <= 1'b0;
      fault_q   <= 1'b0;
      icount    <= '0;
    end else begin
      case (state_q)
        SEQ_HALT: begin
          if (!halt_req) begin
            if (run) begin
              state_q   <= SEQ_FETCH;
              step_mode <= 1'b0;
            end else if (step) begin
              state_q   <= SEQ_FETCH;
              step_mode <= 1'b1;
            end
          end
        end
        SEQ_FETCH: state_q <= SEQ_DECODE;
        SEQ_DECODE: begin
          if (is_alu(opcode)) begin
            state_q <= SEQ_EXEC;
          end else if (is_load || is_store) begin
            state_q <= SEQ_MEM;
          end else if (opcode == OP_IO) begin
            state_q <= SEQ_IO;
          end else begin
            icount    <= icount + ICNT_W'(1);
            step_mode <= 1'b0;
            state_q   <= is_haltop ? SEQ_HALT : boundary_state;
          end
        end
        SEQ_EXEC: state_q <= SEQ_WB;
        SEQ_MEM: begin
          if (mem_ack) begin
            if (is_store) begin
              icount    <= icount + ICNT_W'(1);
              step_mode <= 1'b0;
              state_q   <= boundary_state;
            end else begin
              state_q <= SEQ_WB;
            end
          end else if (tmo_expired) begin
            state_q <= SEQ_FAULT;
            fault_q <= 1'b1;
          end
        end
        SEQ_IO: begin
          if (is_in) begin
            if (in_valid) state_q <= SEQ_WB;
          end else if (out_ready) begin
            icount    <= icount + ICNT_W'(1);
            step_mode <= 1'b0;
            state_q   <= boundary_state;
          end
        end
        SEQ_WB: begin
          icount    <= icount + ICNT_W'(1);
          step_mode <= 1'b0;
          state_q   <= boundary_state;
        end
        SEQ_FAULT: state_q <= SEQ_FAULT;
        default:   state_q <= SEQ_HALT;
      endcase
    end
  end

  // Strobes decode from the state register; IO strobes follow the handshake.
  assign fetch_en    = (state_q == SEQ_FETCH);
  assign exec_en     = (state_q == SEQ_EXEC);
  assign wb_en       = (state_q == SEQ_WB);
  assign mem_req     = (state_q == SEQ_MEM);
  assign mem_we      = (state_q == SEQ_MEM) && is_store;
  assign in_pop      = (state_q == SEQ_IO) && is_in  && in_valid;
  assign out_push    = (state_q == SEQ_IO) && is_out && out_ready;
  assign halted      = (state_q == SEQ_HALT);
  assign fault       = fault_q;
  assign state       = state_q;
  assign instr_count = icount;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-instruction strobe traces built from the phase rules.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int ICNT_W      = 4;
  localparam int MEM_TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              rst, mode, run, step, halt_req, mem_ack, in_valid, out_ready;
  logic [2:0]        opcode;
  logic              fetch_en, exec_en, wb_en, mem_req, mem_we, in_pop, out_push;
  logic [3:0]        state;
  logic              halted, fault;
  logic [ICNT_W-1:0] instr_count;
  logic [7:0]        obs;

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .ICNT_W(ICNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mode(mode), .run(run), .step(step),
    .halt_req(halt_req), .mem_ack(mem_ack), .in_valid(in_valid), .out_ready(out_ready),
    .fetch_en(fetch_en), .exec_en(exec_en), .wb_en(wb_en), .mem_req(mem_req),
    .mem_we(mem_we), .in_pop(in_pop), .out_push(out_push), .state(state),
    .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  // {halted, fetch, exec, wb, req, we, pop, push}
  assign obs = {halted, fetch_en, exec_en, wb_en, mem_req, mem_we, in_pop, out_push};

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input string tag);
    run = 1'b1; halt_req = 1'b0; step = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL %s start: halted=%b required 1", tag, halted);
    end
    next_edge();
  endtask

  // stop: 0 keep running, 1 drop run during the instruction, 2 raise halt_req in
  // cycle 2, 3 instruction was launched by step.
  task automatic run_instr(input logic [2:0] op, input logic md, input int w,
                           input int stop, input string tag);
    logic [7:0] exp_q[$];
    int cls, len;
    bit halt_exp;
    exp_q = {};
    if (op < 3'd4)                 cls = 0;
    else if (op == 3'd4)           cls = 1;
    else if (op == 3'd5)           cls = 2;
    else if (op == 3'd6)           cls = md ? 4 : 3;
    else                           cls = md ? 5 : 6;
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h00);
    case (cls)
      0: begin exp_q.push_back(8'h20); exp_q.push_back(8'h10); end
      1: begin for (int k = 0; k <= w; k++) exp_q.push_back(8'h08); exp_q.push_back(8'h10); end
      2: for (int k = 0; k <= w; k++) exp_q.push_back(8'h0C);
      3: begin
        for (int k = 0; k <= w; k++) exp_q.push_back((k == w) ? 8'h02 : 8'h00);
        exp_q.push_back(8'h10);
      end
      4: for (int k = 0; k <= w; k++) exp_q.push_back((k == w) ? 8'h01 : 8'h00);
      default: ;
    endcase
    len = exp_q.size();
    for (int i = 0; i < len; i++) begin
      opcode    = op;
      mode      = md;
      mem_ack   = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step      = 1'($urandom_range(0, 1));
      if (i >= 2 && i <= 2 + w) begin
        if (cls == 1 || cls == 2) mem_ack   = (i == 2 + w);
        if (cls == 3)             in_valid  = (i == 2 + w);
        if (cls == 4)             out_ready = (i == 2 + w);
      end
      if (stop == 1) run = 1'b0;
      if (stop == 2 && i == 2) halt_req = 1'b1;
      #1;
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL %s cycle %0d: strobes=%b required %b", tag, i, obs, exp_q[i]);
      end
      next_edge();
    end
    step = 1'b0; mem_ack = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << ICNT_W);
    halt_exp = (stop != 0) || (cls == 6);
    #1;
    checks++;
    if (instr_count !== ICNT_W'(exp_count)) begin
      failures++;
      $display("FAIL %s count: instr_count=%0d required %0d", tag, instr_count, exp_count);
    end
    checks++;
    if (halted !== halt_exp) begin
      failures++;
      $display("FAIL %s boundary: halted=%b required %b", tag, halted, halt_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; opcode = 3'd0; mode = 1'b0;
    mem_ack = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    next_edge();
    next_edge();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== SEQ_HALT) begin
      failures++; $display("FAIL reset_state: state=%0d required %0d", state, SEQ_HALT);
    end
    checks++;
    if (obs !== 8'h80) begin
      failures++; $display("FAIL reset_strobes: %b required 10000000", obs);
    end
    checks++;
    if (fault !== 1'b0 || instr_count !== '0) begin
      failures++; $display("FAIL reset_fault_count: fault=%b count=%0d required 0/0", fault, instr_count);
    end
    exp_count = 0;
  endtask

  task automatic test_alu_run();
    start_run("alu");
    for (int n = 0; n < 3; n++) run_instr(3'd0, 1'b0, 0, (n == 2) ? 1 : 0, "alu");
  endtask

  task automatic test_mem();
    start_run("mem");
    run_instr(OP_LOAD,  1'b0, 3, 0, "load_wait3");
    run_instr(OP_STORE, 1'b0, 0, 0, "store_ack0");
    run_instr(OP_STORE, 1'b0, MEM_TIMEOUT - 1, 0, "store_last");
    run_instr(OP_LOAD,  1'b0, 0, 1, "load_ack0");
  endtask

  task automatic test_io();
    start_run("io");
    run_instr(OP_IO, 1'b0, 5, 0, "in_wait5");
    run_instr(OP_IO, 1'b1, 0, 0, "out_ready");
    run_instr(OP_IO, 1'b1, 3, 1, "out_wait3");
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic md;
    int w;
    start_run("rand");
    for (int n = 0; n < 30; n++) begin
      op = 3'($urandom_range(0, 7));
      md = 1'($urandom_range(0, 1));
      if (op == OP_SYS) md = 1'b1;
      w = 0;
      if (op == OP_LOAD || op == OP_STORE) w = $urandom_range(0, MEM_TIMEOUT - 1);
      if (op == OP_IO) w = $urandom_range(0, 5);
      run_instr(op, md, w, (n == 29) ? 1 : 0, "rand");
    end
  endtask

  task automatic test_step();
    run = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_edge();
      checks++;
      if (halted !== 1'b1) begin
        failures++; $display("FAIL halt_req_blocks: halted=%b required 1", halted);
      end
    end
    run = 1'b0; halt_req = 1'b0; step = 1'b1; opcode = 3'd0; mode = 1'b0;
    next_edge();
    step = 1'b0;
    run_instr(3'd2, 1'b0, 0, 3, "step_alu");
    next_edge();
    checks++;
    if (halted !== 1'b1) begin
      failures++; $display("FAIL step_stays: halted=%b required 1", halted);
    end
    step = 1'b1;
    next_edge();
    step = 1'b0;
    run_instr(OP_SYS, 1'b1, 0, 3, "step_nop");
  endtask

  task automatic test_halt_req();
    start_run("hreq");
    run_instr(3'd1, 1'b0, 0, 0, "hreq_first");
    run_instr(3'd3, 1'b0, 0, 2, "hreq_exec");
    run = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_sys();
    start_run("sys");
    run_instr(OP_SYS, 1'b1, 0, 0, "nop");
    run_instr(OP_SYS, 1'b1, 0, 0, "nop2");
    run_instr(3'd0,   1'b0, 0, 0, "alu_after_nop");
    run_instr(OP_SYS, 1'b0, 0, 0, "halt_op");
    run = 1'b0;
    next_edge();
    checks++;
    if (halted !== 1'b1) begin
      failures++; $display("FAIL halt_op_stays: halted=%b required 1", halted);
    end
  endtask

  task automatic test_rst_mid();
    start_run("rstmid");
    opcode = OP_LOAD; mode = 1'b0; mem_ack = 1'b0;
    next_edge();
    next_edge();
    next_edge();
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_mem: mem_req=%b required 1", mem_req);
    end
    rst = 1'b1; run = 1'b0;
    next_edge();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== SEQ_HALT || obs !== 8'h80 || instr_count !== '0) begin
      failures++;
      $display("FAIL rstmid_abort: state=%0d strobes=%b count=%0d required %0d/10000000/0",
               state, obs, instr_count, SEQ_HALT);
    end
    exp_count = 0;
  endtask

  task automatic test_timeout();
    start_run("tmo");
    opcode = OP_LOAD; mode = 1'b0;
    for (int i = 0; i < 2 + MEM_TIMEOUT; i++) begin
      mem_ack = (i < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      checks++;
      if (obs !== ((i == 0) ? 8'h40 : (i == 1) ? 8'h00 : 8'h08)) begin
        failures++; $display("FAIL tmo_cycle %0d: strobes=%b", i, obs);
      end
      next_edge();
    end
    for (int i = 0; i < 6; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      mem_ack = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (state !== SEQ_FAULT || fault !== 1'b1 || obs !== 8'h00) begin
        failures++;
        $display("FAIL tmo_fault %0d: state=%0d fault=%b strobes=%b required %0d/1/00000000",
                 i, state, fault, obs, SEQ_FAULT);
      end
      next_edge();
    end
    rst = 1'b1; run = 1'b0; step = 1'b0; mem_ack = 1'b0;
    next_edge();
    rst = 1'b0;
    #1;
    checks++;
    if (fault !== 1'b0 || halted !== 1'b1) begin
      failures++; $display("FAIL tmo_rst_clears: fault=%b halted=%b required 0/1", fault, halted);
    end
    exp_count = 0;
  endtask

  initial begin
    test_reset();
    test_alu_run();
    test_mem();
    test_io();
    test_random();
    test_step();
    test_halt_req();
    test_sys();
    test_rst_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
